sensor_conditioner: RTL and testbench

- Input-conditioning stage that sits directly upstream of the traffic controller.
- Takes the raw side-road car detector and the raw emergency-vehicle request, synchronises and debounces both, and drives the controller's C and Emergency inputs.
- Emergency requests are stretched with a hold time. A stuck request is cut off by a maximum-duration watchdog that raises a fault flag.

---
 rtl/sensor_conditioner.sv | 174 +++++++++++++++++
 tb/tb_sensor_conditioner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// Synchronises and debounces the raw car detector and emergency request feeding the traffic controller.
// Optional macro CAR_LATCH_EN turns C into a request latch that is cleared by car_served.
module sensor_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int EMG_DEB    = 2,
    parameter int EMG_HOLD   = 8,
    parameter int EMG_MAX    = 1000
) (
    input  logic Clk,
    input  logic reset,
    input  logic car_raw,
    input  logic emg_raw,
    input  logic car_served,
    output logic C,
    output logic Emergency,
    output logic emg_fault
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam int EW = $clog2(EMG_DEB) + 1;
    localparam int DW = $clog2(EMG_MAX) + 1;
    localparam int HW = $clog2(EMG_HOLD) + 1;

    localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [EW-1:0] E_LAST = EW'(EMG_DEB - 1);
    localparam logic [DW-1:0] D_LAST = DW'(EMG_MAX - 1);
    localparam logic [HW-1:0] H_LAST = HW'(EMG_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLD    = 2'd2,
        LOCKOUT = 2'd3
    } emg_state_t;

    logic car_meta, car_s, emg_meta, emg_s;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            car_meta <= 1'b0;
            car_s    <= 1'b0;
            emg_meta <= 1'b0;
            emg_s    <= 1'b0;
        end else begin
            car_meta <= car_raw;
            car_s    <= car_meta;
            emg_meta <= emg_raw;
            emg_s    <= emg_meta;
        end
    end

    // Car debounce: any single sample agreeing with the current level restarts the count.
    logic [CW-1:0] cnt_c;
    logic          car_deb;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            cnt_c   <= '0;
            car_deb <= 1'b0;
        end else if (car_s == car_deb) begin
            cnt_c <= '0;
        end else if (cnt_c == C_LAST) begin
            car_deb <= car_s;
            cnt_c   <= '0;
        end else begin
            cnt_c <= cnt_c + 1'b1;
        end
    end

`ifdef CAR_LATCH_EN
    logic car_rise;
    assign car_rise = (car_s != car_deb) && (cnt_c == C_LAST) && car_s;

    // Set has priority so a served pulse cannot swallow a fresh arrival.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset)          C <= 1'b0;
        else if (car_rise)   C <= 1'b1;
        else if (car_served) C <= 1'b0;
    end
`else
    logic unused_car_served;
    assign unused_car_served = car_served;
    assign C = car_deb;
`endif

    emg_state_t    state, state_n;
    logic [EW-1:0] cnt_e, cnt_e_n;
    logic [DW-1:0] dur, dur_n, dur_inc;
    logic [HW-1:0] hold, hold_n;
    logic          emg_n, fault_n;

    assign dur_inc = (dur == D_LAST) ? dur : dur + 1'b1;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt_e     <= '0;
            dur       <= '0;
            hold      <= '0;
            Emergency <= 1'b0;
            emg_fault <= 1'b0;
        end else begin
            state     <= state_n;
            cnt_e     <= cnt_e_n;
            dur       <= dur_n;
            hold      <= hold_n;
            Emergency <= emg_n;
            emg_fault <= fault_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_e_n = cnt_e;
        dur_n   = dur;
        hold_n  = hold;
        emg_n   = Emergency;
        fault_n = emg_fault;
        case (state)
            IDLE: begin
                emg_n   = 1'b0;
                fault_n = 1'b0;
                dur_n   = '0;
                hold_n  = '0;
                if (!emg_s) begin
                    cnt_e_n = '0;
                end else if (cnt_e == E_LAST) begin
                    state_n = ACTIVE;
                    emg_n   = 1'b1;
                    cnt_e_n = '0;
                end else begin
                    cnt_e_n = cnt_e + 1'b1;
                end
            end
            ACTIVE: begin
                emg_n = 1'b1;
                dur_n = dur_inc;
                // A drop on the limit edge is a normal release, not a fault.
                if (!emg_s) begin
                    state_n = HOLD;
                    hold_n  = '0;
                end else if (dur == D_LAST) begin
                    state_n = LOCKOUT;
                    emg_n   = 1'b0;
                    fault_n = 1'b1;
                end
            end
            HOLD: begin
                emg_n = 1'b1;
                dur_n = dur_inc;
                if (emg_s) begin
                    state_n = ACTIVE;
                    hold_n  = '0;
                end else if (hold == H_LAST) begin
                    state_n = IDLE;
                    emg_n   = 1'b0;
                end else begin
                    hold_n = hold + 1'b1;
                end
            end
            LOCKOUT: begin
                emg_n   = 1'b0;
                fault_n = 1'b1;
                if (!emg_s) begin
                    state_n = IDLE;
                    fault_n = 1'b0;
                    cnt_e_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner (DEB_CYCLES=4, EMG_DEB=2, EMG_HOLD=8, EMG_MAX=20).
// Tick i below means the i-th rising edge after an input was changed.
module tb_sensor_conditioner;

    logic Clk, reset, car_raw, emg_raw, car_served;
    logic C, Emergency, emg_fault;
    int   passed = 0;
    int   total  = 0;

`ifdef CAR_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    sensor_conditioner #(.DEB_CYCLES(4), .EMG_DEB(2), .EMG_HOLD(8), .EMG_MAX(20)) dut (
        .Clk(Clk), .reset(reset), .car_raw(car_raw), .emg_raw(emg_raw),
        .car_served(car_served), .C(C), .Emergency(Emergency), .emg_fault(emg_fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({C, Emergency, emg_fault} !== 3'b000)
            $display("FAIL reset_outputs got=%b exp=000", {C, Emergency, emg_fault});
        else passed++;
        reset = 1'b1;
        tick();
        total++;
        if ({C, Emergency, emg_fault} !== 3'b000)
            $display("FAIL after_release got=%b exp=000", {C, Emergency, emg_fault});
        else passed++;
    endtask

    task automatic test_car();
        logic exp;
        car_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = (i >= 6);
            total++;
            if (C !== exp) $display("FAIL car_rise tick=%0d got=%b exp=%b", i, C, exp);
            else passed++;
        end
        car_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = LATCH | (i < 6);
            total++;
            if (C !== exp) $display("FAIL car_fall tick=%0d got=%b exp=%b", i, C, exp);
            else passed++;
        end
        if (LATCH) begin
            car_served = 1'b1;
            tick();
            car_served = 1'b0;
        end
    endtask

    task automatic test_short_pulse();
        car_raw = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        car_raw = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            total++;
            if (C !== 1'b0) $display("FAIL short_pulse tick=%0d got=%b exp=0", i, C);
            else passed++;
        end
        total++;
        if (dut.cnt_c !== '0) $display("FAIL short_cnt got=%0d exp=0", dut.cnt_c);
        else passed++;
    endtask

`ifdef CAR_LATCH_EN
    task automatic test_car_served();
        car_raw = 1'b1;
        for (int i = 1; i <= 8; i++) tick();
        total++;
        if (C !== 1'b1) $display("FAIL latch_set got=%b exp=1", C);
        else passed++;
        car_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (C !== 1'b1) $display("FAIL latch_hold got=%b exp=1", C);
        else passed++;
        car_served = 1'b1;
        tick();
        car_served = 1'b0;
        total++;
        if (C !== 1'b0) $display("FAIL latch_clear got=%b exp=0", C);
        else passed++;
        tick();
        total++;
        if (C !== 1'b0) $display("FAIL latch_stays_clear got=%b exp=0", C);
        else passed++;
    endtask
`else
    task automatic test_car_served();
        car_raw = 1'b1;
        for (int i = 1; i <= 8; i++) tick();
        car_served = 1'b1;
        tick();
        car_served = 1'b0;
        total++;
        if (C !== 1'b1) $display("FAIL served_ignored got=%b exp=1", C);
        else passed++;
        car_raw = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        total++;
        if (C !== 1'b0) $display("FAIL served_fall got=%b exp=0", C);
        else passed++;
    endtask
`endif

    task automatic test_emg_basic();
        logic exp;
        emg_raw = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp = (i >= 4);
            total++;
            if (Emergency !== exp) $display("FAIL emg_rise tick=%0d got=%b exp=%b", i, Emergency, exp);
            else passed++;
        end
        emg_raw = 1'b0;
        // Drop reaches emg_s on tick 2, HOLD entered on tick 3, eight HOLD edges follow.
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp = (j <= 10);
            total++;
            if ({Emergency, emg_fault} !== {exp, 1'b0})
                $display("FAIL emg_hold tick=%0d got=%b exp=%b", j, {Emergency, emg_fault}, {exp, 1'b0});
            else passed++;
        end
    endtask

    task automatic test_emg_reassert();
        logic exp;
        emg_raw = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        emg_raw = 1'b0;
        for (int i = 6; i <= 8; i++) tick();
        emg_raw = 1'b1;
        for (int i = 9; i <= 11; i++) begin
            tick();
            total++;
            if (Emergency !== 1'b1) $display("FAIL reassert_emg edge=%0d got=%b exp=1", i, Emergency);
            else passed++;
            if (i == 10) begin
                total++;
                if (dut.hold !== 4'd2) $display("FAIL reassert_hold got=%0d exp=2", dut.hold);
                else passed++;
            end
        end
        total++;
        if ({dut.state, dut.hold} !== {2'd1, 4'd0})
            $display("FAIL reassert_active got=%0d/%0d exp=1/0", dut.state, dut.hold);
        else passed++;
        tick();
        emg_raw = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp = (j <= 10);
            total++;
            if (Emergency !== exp) $display("FAIL reassert_drop tick=%0d got=%b exp=%b", j, Emergency, exp);
            else passed++;
            if (j == 3) begin
                total++;
                if ({dut.state, dut.hold} !== {2'd2, 4'd0})
                    $display("FAIL reassert_rehold got=%0d/%0d exp=2/0", dut.state, dut.hold);
                else passed++;
            end
        end
    endtask

    task automatic test_lockout();
        logic e_exp, f_exp;
        emg_raw = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            e_exp = (i >= 4) && (i <= 23);
            f_exp = (i >= 24);
            total++;
            if ({Emergency, emg_fault} !== {e_exp, f_exp})
                $display("FAIL lockout tick=%0d got=%b exp=%b", i, {Emergency, emg_fault}, {e_exp, f_exp});
            else passed++;
        end
        emg_raw = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            f_exp = (j <= 2);
            total++;
            if ({Emergency, emg_fault} !== {1'b0, f_exp})
                $display("FAIL lockout_clear tick=%0d got=%b exp=%b", j, {Emergency, emg_fault}, {1'b0, f_exp});
            else passed++;
        end
        emg_raw = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            e_exp = (k >= 4);
            total++;
            if ({Emergency, emg_fault} !== {e_exp, 1'b0})
                $display("FAIL lockout_redeb tick=%0d got=%b exp=%b", k, {Emergency, emg_fault}, {e_exp, 1'b0});
            else passed++;
        end
        emg_raw = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        total++;
        if (Emergency !== 1'b0) $display("FAIL lockout_idle got=%b exp=0", Emergency);
        else passed++;
    endtask

    task automatic test_reset_mid_hold();
        car_raw = 1'b1;
        emg_raw = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        emg_raw = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if ({C, Emergency, dut.state} !== {1'b1, 1'b1, 2'd2})
            $display("FAIL pre_reset got=%b exp=1110", {C, Emergency, dut.state});
        else passed++;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({C, Emergency, emg_fault, dut.state} !== 5'b00000)
            $display("FAIL async_reset got=%b exp=00000", {C, Emergency, emg_fault, dut.state});
        else passed++;
        car_raw = 1'b0;
        tick();
        @(negedge Clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if ({C, Emergency, emg_fault} !== 3'b000)
            $display("FAIL post_reset got=%b exp=000", {C, Emergency, emg_fault});
        else passed++;
    endtask

    initial begin
        reset      = 1'b0;
        car_raw    = 1'b0;
        emg_raw    = 1'b0;
        car_served = 1'b0;
        test_reset();
        test_car();
        test_short_pulse();
        test_car_served();
        for (int i = 0; i < 4; i++) tick();
        test_emg_basic();
        test_emg_reassert();
        test_lockout();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
